// File: rtl/roce_icrc_stream_arbiter.sv
// Packet-granular round-robin arbiter merging PORTS AXI-Stream sources into one
// stream for the ICRC engine, with a two-entry skid slice on the output.
module roce_icrc_stream_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PORTS      = 2,
  localparam int unsigned IDW       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [PORTS*DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [PORTS-1:0]               s_axis_tvalid,
  input  logic [PORTS-1:0]               s_axis_tlast,
  input  logic [PORTS-1:0]               s_axis_tuser,
  output logic [PORTS-1:0]               s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic                           m_axis_tready,
  output logic [IDW-1:0]                 m_axis_tid,
  output logic                           busy
);

  localparam int unsigned KW = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
    logic                  user;
    logic [IDW-1:0]        id;
  } beat_t;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] pick, cand;
  logic           ready_q, ready_d;
  logic           in_valid, accept, any_req;
  beat_t          in_beat, out_q, tmp_q;
  logic           out_valid_q, out_valid_d;
  logic           tmp_valid_q, tmp_valid_d;
  logic           in_to_out, in_to_tmp, tmp_to_out;

  assign any_req = |s_axis_tvalid;
  assign accept  = (state_q == S_ACTIVE) && ready_q && in_valid;

  // Select the granted source's beat.
  always_comb begin
    in_beat  = '0;
    in_valid = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant_q == IDW'(i)) begin
        in_beat.data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_beat.keep = s_axis_tkeep[i*KW +: KW];
        in_beat.last = s_axis_tlast[i];
        in_beat.user = s_axis_tuser[i];
        in_valid     = s_axis_tvalid[i];
      end
    end
    in_beat.id = grant_q;
  end

  // Round-robin pick: scanning downward leaves the nearest requester after last_grant.
  always_comb begin
    pick = last_grant_q;
    cand = last_grant_q;
    for (int unsigned k = PORTS; k > 0; k--) begin
      cand = IDW'((32'(last_grant_q) + k) % PORTS);
      if (s_axis_tvalid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && in_beat.last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    busy          = 1'b0;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      S_IDLE: if (any_req) grant_d = pick;
      S_ACTIVE: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < PORTS; i++) begin
          s_axis_tready[i] = ready_q && (grant_q == IDW'(i));
        end
        if (accept && in_beat.last) last_grant_d = grant_q;
      end
      default: ;
    endcase
  end

  // Skid slice: input lands in the output reg when it is free, otherwise in temp.
  always_comb begin
    out_valid_d = out_valid_q;
    tmp_valid_d = tmp_valid_q;
    in_to_out   = 1'b0;
    in_to_tmp   = 1'b0;
    tmp_to_out  = 1'b0;
    ready_d     = m_axis_tready || (!out_valid_q && !tmp_valid_q);
    if (ready_q) begin
      if (m_axis_tready || !out_valid_q) begin
        out_valid_d = accept;
        in_to_out   = accept;
      end else begin
        tmp_valid_d = accept;
        in_to_tmp   = accept;
      end
    end else if (m_axis_tready) begin
      out_valid_d = tmp_valid_q;
      tmp_valid_d = 1'b0;
      tmp_to_out  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= IDW'(PORTS - 1);
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      tmp_valid_q  <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      tmp_valid_q  <= tmp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_to_out)       out_q <= in_beat;
    else if (tmp_to_out) out_q <= tmp_q;
    if (in_to_tmp)       tmp_q <= in_beat;
  end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tid    = out_q.id;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_roce_icrc_stream_arbiter.sv
// Directed and randomized bench for roce_icrc_stream_arbiter (PORTS=4) with a
// per-port packet scoreboard.
module tb_roce_icrc_stream_arbiter;

  localparam int unsigned DW  = 64;
  localparam int unsigned P   = 4;
  localparam int unsigned KW  = DW / 8;
  localparam int unsigned IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [P*DW-1:0]   s_tdata;
  logic [P*KW-1:0]   s_tkeep;
  logic [P-1:0]      s_tvalid, s_tlast, s_tuser, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid, m_tlast, m_tuser, m_tready, busy;
  logic [IDW-1:0]    m_tid;

  roce_icrc_stream_arbiter #(.DATA_WIDTH(DW), .PORTS(P)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    int    cyc;
    int    port;
    beat_t b;
  } ev_t;

  beat_t        src_q[P][$];
  beat_t        exp_q[P][$];
  ev_t          in_log[$];
  ev_t          out_log[$];
  logic         busy_log[$];
  logic [P-1:0] rdy_log[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           total_beats = 0;
  bit           out_in_pkt = 0;
  int           out_port = 0;
  bit           rand_rdy = 0;
  bit           gaps = 0;
  logic [P-1:0] last_rdy;
  logic         last_busy, last_mvalid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input logic [KW-1:0] keep_last, input bit user);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = (i == len - 1) ? keep_last : {KW{1'b1}};
      b.last = (i == len - 1);
      b.user = user;
      src_q[p].push_back(b);
      total_beats++;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      if (src_q[p].size() != 0 && (!gaps || $urandom_range(0, 4) != 0)) begin
        s_tvalid[p]           = 1'b1;
        s_tdata[p*DW +: DW]   = src_q[p][0].data;
        s_tkeep[p*KW +: KW]   = src_q[p][0].keep;
        s_tlast[p]            = src_q[p][0].last;
        s_tuser[p]            = src_q[p][0].user;
      end else begin
        s_tvalid[p]           = 1'b0;
        s_tdata[p*DW +: DW]   = '0;
        s_tkeep[p*KW +: KW]   = '0;
        s_tlast[p]            = 1'b0;
        s_tuser[p]            = 1'b0;
      end
    end
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: sample handshakes at negedge, update stimulus just after posedge.
  task automatic step();
    ev_t   e;
    beat_t got;
    int    t;
    @(negedge clk);
    last_rdy    = s_tready;
    last_busy   = busy;
    last_mvalid = m_tvalid;
    rdy_log.push_back(s_tready);
    busy_log.push_back(busy);
    chk("ready_onehot0", 128'($onehot0(s_tready)), 128'(1));
    for (int p = 0; p < P; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        e.cyc  = cyc;
        e.port = p;
        e.b    = src_q[p].pop_front();
        exp_q[p].push_back(e.b);
        in_log.push_back(e);
      end
    end
    if (m_tvalid && m_tready) begin
      t   = int'(m_tid);
      got = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (out_in_pkt) chk("no_interleave", 128'(t), 128'(out_port));
      chk($sformatf("beat_expected_p%0d", t), 128'(exp_q[t].size() != 0), 128'(1));
      if (exp_q[t].size() != 0) chk($sformatf("out_beat_p%0d", t), 128'(got), 128'(exp_q[t].pop_front()));
      e.cyc  = cyc;
      e.port = t;
      e.b    = got;
      out_log.push_back(e);
      out_in_pkt = !m_tlast;
      out_port   = t;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic clear_logs();
    in_log.delete();
    out_log.delete();
    busy_log.delete();
    rdy_log.delete();
    cyc = 0;
  endtask

  function automatic bit pending();
    for (int p = 0; p < P; p++)
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b1;
    return m_tvalid;
  endfunction

  task automatic run_until_drained(input int budget, input string tag);
    int n = 0;
    while (n < budget && pending()) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 128'(n < budget), 128'(1));
  endtask

  initial begin
    #990000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] busy_exp;
    beat_t      b32;
    int         last0, first1, hs0, n;

    rst = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b1;

    // Two 3-beat packets contending straight out of reset.
    repeat (3) @(posedge clk);
    #1;
    add_pkt(0, 3, 8'hFF, 1'b0);
    add_pkt(1, 3, 8'hFF, 1'b0);
    drive();
    @(negedge clk);
    chk("reset_ready", 128'(s_tready), 128'(0));
    chk("reset_mvalid", 128'(m_tvalid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    step();
    chk("release_ready_low", 128'(last_rdy), 128'(0));
    run_until_drained(40, "t1");
    chk("t1_out_count", 128'(out_log.size()), 128'(6));
    if (out_log.size() == 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("t1_tid_%0d", k), 128'(out_log[k].port), 128'((k < 3) ? 0 : 1));
      chk("t1_first_out_cyc", 128'(out_log[0].cyc), 128'(2));
      chk("t1_back_to_back", 128'(out_log[2].cyc - out_log[0].cyc), 128'(2));
      chk("t1_bubble", 128'(out_log[3].cyc - out_log[2].cyc), 128'(2));
    end
    busy_exp = 9'b011101110;
    chk("t1_busy_len", 128'(busy_log.size() >= 9), 128'(1));
    if (busy_log.size() >= 9)
      for (int i = 0; i < 9; i++) chk($sformatf("t1_busy_c%0d", i), 128'(busy_log[i]), 128'(busy_exp[i]));

    // Single-beat packet on port 1 with partial keep and error flag.
    clear_logs();
    add_pkt(1, 1, 8'h0F, 1'b1);
    b32 = src_q[1][0];
    drive();
    run_until_drained(20, "t2");
    chk("t2_out_count", 128'(out_log.size()), 128'(1));
    chk("t2_in_count", 128'(in_log.size()), 128'(1));
    if (out_log.size() == 1 && in_log.size() == 1) begin
      chk("t2_tid", 128'(out_log[0].port), 128'(1));
      chk("t2_data", 128'(out_log[0].b.data), 128'(b32.data));
      chk("t2_keep", 128'(out_log[0].b.keep), 128'(8'h0F));
      chk("t2_last", 128'(out_log[0].b.last), 128'(1));
      chk("t2_user", 128'(out_log[0].b.user), 128'(1));
      chk("t2_latency", 128'(out_log[0].cyc - in_log[0].cyc), 128'(1));
    end

    // Port 1 requests while port 0 is mid-packet.
    clear_logs();
    add_pkt(0, 4, 8'hFF, 1'b0);
    drive();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) add_pkt(1, 2, 8'h3F, 1'b0);
      step();
    end
    run_until_drained(40, "t3");
    last0 = -1;
    first1 = -1;
    foreach (in_log[i]) begin
      if (in_log[i].port == 0 && in_log[i].b.last) last0 = in_log[i].cyc;
      if (in_log[i].port == 1 && first1 < 0) first1 = in_log[i].cyc;
    end
    n = -1;
    foreach (rdy_log[i]) if (n < 0 && rdy_log[i][1]) n = i;
    chk("t3_ready1_first", 128'(n), 128'(last0 + 2));
    chk("t3_port1_first_hs", 128'(first1), 128'(last0 + 2));

    // Reset in the middle of a 5-beat packet.
    clear_logs();
    add_pkt(0, 5, 8'hFF, 1'b0);
    add_pkt(1, 3, 8'h01, 1'b0);
    drive();
    hs0 = 0;
    n = 0;
    while (n < 20 && hs0 < 2) begin
      step();
      hs0 = 0;
      foreach (in_log[i]) if (in_log[i].port == 0) hs0++;
      n++;
    end
    chk("t4_reached_beat2", 128'(n < 20), 128'(1));
    rst = 1'b1;
    step();
    for (int p = 0; p < P; p++) exp_q[p].delete();
    src_q[0].delete();
    out_in_pkt = 0;
    step();
    chk("t4_mvalid_after_rst", 128'(last_mvalid), 128'(0));
    chk("t4_ready_after_rst", 128'(last_rdy), 128'(0));
    chk("t4_busy_after_rst", 128'(last_busy), 128'(0));
    rst = 1'b0;
    add_pkt(0, 2, 8'h7F, 1'b0);
    drive();
    clear_logs();
    step();
    chk("t4_release_ready_low", 128'(last_rdy), 128'(0));
    run_until_drained(60, "t4");
    chk("t4_out_count", 128'(out_log.size()), 128'(5));
    if (in_log.size() != 0) chk("t4_first_grant", 128'(in_log[0].port), 128'(0));
    if (out_log.size() != 0) chk("t4_first_tid", 128'(out_log[0].port), 128'(0));

    // All four ports streaming single-beat packets from reset.
    rst = 1'b1;
    for (int p = 0; p < P; p++)
      for (int j = 0; j < 3; j++) add_pkt(p, 1, 8'hFF, 1'b0);
    drive();
    step();
    step();
    for (int p = 0; p < P; p++) exp_q[p].delete();
    out_in_pkt = 0;
    rst = 1'b0;
    clear_logs();
    run_until_drained(80, "t5");
    chk("t5_in_count", 128'(in_log.size()), 128'(12));
    chk("t5_out_count", 128'(out_log.size()), 128'(12));
    if (in_log.size() == 12 && out_log.size() == 12) begin
      chk("t5_first_hs_cyc", 128'(in_log[0].cyc), 128'(1));
      chk("t5_bubble_idle", 128'(busy_log[in_log[0].cyc + 1]), 128'(0));
      for (int k = 0; k < 12; k++) begin
        chk($sformatf("t5_grant_%0d", k), 128'(in_log[k].port), 128'(k % P));
        chk($sformatf("t5_tid_%0d", k), 128'(out_log[k].port), 128'(k % P));
        if (k > 0) chk($sformatf("t5_spacing_%0d", k), 128'(in_log[k].cyc - in_log[k-1].cyc), 128'(2));
      end
    end

    // 1000 random packets with random backpressure and source gaps.
    clear_logs();
    total_beats = 0;
    for (int i = 0; i < 1000; i++)
      add_pkt($urandom_range(0, P - 1), $urandom_range(1, 8), 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
    rand_rdy = 1;
    gaps = 1;
    drive();
    run_until_drained(60000, "t6");
    chk("t6_in_beats", 128'(in_log.size()), 128'(total_beats));
    chk("t6_out_beats", 128'(out_log.size()), 128'(total_beats));
    for (int p = 0; p < P; p++) chk($sformatf("t6_scoreboard_empty_p%0d", p), 128'(exp_q[p].size()), 128'(0));
    rand_rdy = 0;
    gaps = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/roce_icrc_stream_arbiter.md
ROCE_ICRC_STREAM_ARBITER -- requirements
Module: roce_icrc_stream_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning tdata width in bits (multiple of 8).
REQ-002 The block SHALL have parameter PORTS, default 2, meaning number of input streams (legal 2..4); IDW = max(1, clog2(PORTS)).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata  input  PORTS*DATA_WIDTH  packed input data; port i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 s_axis_tkeep  input  PORTS*DATA_WIDTH/8  packed byte enables.
REQ-007 s_axis_tvalid, s_axis_tlast, s_axis_tuser  input  PORTS each  per-port valid, end-of-packet, error flag.
REQ-008 s_axis_tready  output  PORTS  per-port ready.
REQ-009 m_axis_tdata/tkeep/tvalid/tlast/tuser  output  DATA_WIDTH/DATA_WIDTH/8/1/1/1  merged stream toward the ICRC mask/CRC engine.
REQ-010 m_axis_tready  input  1  downstream ready.
REQ-011 m_axis_tid  output  IDW  index of source port of current output beat.
REQ-012 busy  output  1  high while state is ACTIVE.

Function
REQ-013 The block SHALL share one output stream among PORTS requesters with packet-granular round-robin arbitration; a grant is never changed mid-packet.
REQ-014 States: IDLE, ACTIVE.
REQ-015 IDLE: all s_axis_tready low; if any s_axis_tvalid high, select the first requesting port scanning last_grant+1, last_grant+2, ... modulo PORTS; register grant, go ACTIVE next cycle.
REQ-016 IDLE with no s_axis_tvalid: remain IDLE, grant and last_grant unchanged.
REQ-017 ACTIVE: s_axis_tready[grant] = internal ready (REQ-021); all other s_axis_tready bits low.
REQ-018 ACTIVE: beat accepted when s_axis_tvalid[grant] and s_axis_tready[grant] both high; accepted beat forwarded with tdata, tkeep, tlast, tuser unmodified and m_axis_tid = grant.
REQ-019 Accepted beat with tlast high: last_grant <= grant, state <= IDLE; exactly one IDLE cycle between packets (arbitration bubble).
REQ-020 Request changes on non-granted ports during ACTIVE SHALL have no effect; s_axis_tvalid drop on granted port mid-packet stalls without releasing grant.
REQ-021 Output path SHALL be a two-entry register slice (output reg + temp reg); internal ready registered = m_axis_tready OR both entries empty.
REQ-022 Latency: beat accepted in cycle N appears on m_axis_* in cycle N+1 when output not stalled.
REQ-023 No beat SHALL be lost or duplicated under arbitrary m_axis_tready backpressure; temp entry drains to output when m_axis_tready high and input not ready.
REQ-024 Throughput: one beat per cycle within a packet with m_axis_tready held high.
REQ-025 Single-beat packet (tlast on first beat) SHALL complete in ACTIVE for one accepted beat, then IDLE.
REQ-026 Fairness: with all ports continuously requesting, grant sequence is 0,1,...,PORTS-1,0,...; no port waits more than PORTS-1 packets.
REQ-027 m_axis_tdata/tkeep/tlast/tuser/tid SHALL be don't-care whenever m_axis_tvalid is low.

Reset
REQ-028 On rst: state IDLE, s_axis_tready all 0, m_axis_tvalid 0, temp valid 0, internal ready 0, busy 0, grant 0, last_grant PORTS-1 (port 0 wins first).
REQ-029 rst asserted mid-packet SHALL discard the partial packet in both slice entries; no further beats of it are emitted; next packet arbitrates from port 0.
REQ-030 First s_axis_tready assertion after reset release SHALL occur no earlier than the second clk edge after rst deasserts.

Verification
REQ-031 PORTS=2, both ports hold a 3-beat packet valid, m_axis_tready=1 -> output port 0 beats (tid=0), one-cycle gap, port 1 beats (tid=1); busy low only in IDLE cycles.
REQ-032 Port 1 alone sends 1-beat packet tkeep=0x0F, tuser=1 -> m_axis_tdata equals input, tkeep=0x0F, tlast=1, tuser=1, tid=1, one cycle after acceptance.
REQ-033 Granted port 0 mid 4-beat packet, port 1 raises tvalid -> s_axis_tready[1] stays 0 until port 0 tlast accepted plus IDLE cycle.
REQ-034 Random m_axis_tready (50%) over 1000 random-length packets on PORTS=4 -> scoreboard per port: byte-exact, in-order, no loss/duplication, tid correct, no interleaving within a packet.
REQ-035 rst pulsed at beat 2 of a 5-beat packet -> m_axis_tvalid 0 the cycle after rst, all s_axis_tready 0; after release, port 0 granted first.
REQ-036 All 4 ports continuously requesting 1-beat packets -> grant order 0,1,2,3,0,1 with every second cycle an IDLE bubble.
